ps2_keycode_fifo: RTL and testbench
===================================

Name: ps2_keycode_fifo

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes its one-cycle byte strobes and folds the 0xE0 (extended) and 0xF0 (break) prefixes into single 10-bit key events.
- Buffers those events in a show-ahead FIFO that the CPU-side bus logic pops.
- Provides empty/full/count/overflow status and a level interrupt.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, log2(DEPTH); pointer width.
- TIMEOUT, 2500000, Hclock cycles allowed between a prefix byte and the next byte before the prefix is discarded (100 ms at 25 MHz).

Ports:
- Hclock  in  1  system clock; all logic on its rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- rd_en  in  1  pop request; one entry per cycle while high.
- rd_data  out  10  head entry: [9]=break, [8]=extended, [7:0]=scan code.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  number of entries held, 0..DEPTH.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.
- irq  out  1  equals !empty.

Behaviour:
Reset (asynchronous, Hreset=1):
- Prefix FSM goes to IDLE; pointers, count and timer are cleared.
- Outputs: overflow=0, empty=1, full=0, count=0, irq=0, rd_data=0.
- Reset mid-sequence discards any pending prefix and all FIFO contents.

Prefix FSM:
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- On rx_valid with 0xE0:
  - IDLE->EXT.
  - In any other state, restart as EXT and drop the partial sequence.
- On rx_valid with 0xF0:
  - IDLE->BRK.
  - EXT->EXT_BRK.
  - BRK and EXT_BRK remain in place (duplicate F0 is ignored).
- On rx_valid with any other byte b:
  - Form event {brk,ext,b}, where brk=1 in BRK/EXT_BRK and ext=1 in EXT/EXT_BRK.
  - Push the event and return to IDLE.
- Filtered bytes: in IDLE, 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF are dropped with no push and no state change.
  - In the prefix states these bytes are treated as codes.

Timeout:
- A timer runs in the three prefix states and is cleared on every rx_valid.
- When it reaches TIMEOUT-1 with no rx_valid, the FSM returns to IDLE and nothing is pushed.
- The timer is held at 0 in IDLE.

FIFO:
- Push happens in the same cycle as the terminating rx_valid.
- The written entry is visible on rd_data and reflected in count/empty on the following cycle.
- rd_data always shows the head entry (show-ahead). rd_en=1 with empty=0 advances the head on that edge.
- rd_en while empty is ignored; no state changes.
- Push while full, without a simultaneous pop: the event is dropped and overflow is set on the next edge.
- Push and pop in the same cycle:
  - Not empty: both occur and count is unchanged, including when full (no overflow).
  - Empty: only the push occurs.
- Pointers wrap modulo DEPTH. count is updated by +1, -1 or 0 in the same edge as the pointers.
- full = (count==DEPTH); empty = (count==0); both are registered or derived from registered count, with no combinational path from rx_valid or rd_en.
- overflow: clr_ovf clears it. If clr_ovf and an overflowing push occur in the same cycle, set wins.

Latency:
- Final byte strobe to irq high: 1 cycle.
- rd_en to next head on rd_data: 1 cycle.

Test Plan:
- Reset, then rx_valid with 0x1C -> one cycle later rd_data=0x01C, count=1, irq=1; pulse rd_en -> empty=1, irq=0.
- Bytes E0,F0,75 (idle cycles between) -> single entry 0x375; bytes F0,1C -> 0x21C; bytes E0,6B -> 0x16B; order preserved on readout.
- Bytes AA then FA in IDLE -> no push, count stays 0; byte E0 then FA -> entry 0x1FA.
- Byte E0, then no byte for TIMEOUT cycles (set TIMEOUT=100 in the bench), then byte 1C -> entry 0x01C (extended bit clear), FSM in IDLE.
- Push 16 codes 0x01..0x10 -> full=1, count=16; push 0x11 -> dropped, overflow=1; push 0x12 with rd_en asserted the same cycle -> count stays 16, head becomes 0x002, tail is 0x012; clr_ovf -> overflow=0.
- Assert Hreset asynchronously between F0 and 1C with 3 entries queued -> count=0, empty=1 immediately; byte 1C after release -> entry 0x01C (break bit clear).

Source files
------------

// File: rtl/ps2_keycode_fifo.sv
// PS/2 scan-code folder and show-ahead event FIFO.
// E0/F0 prefixes are merged into 10-bit events {break, extended, code}, queued for the CPU.
module ps2_keycode_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 2500000
) (
    input  logic          Hclock,
    input  logic          Hreset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rd_en,
    output logic [9:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic          irq
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Bit 1 = break pending, bit 0 = extended pending.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [TW-1:0] timer_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic [9:0]    mem [DEPTH];

    logic is_e0, is_f0, is_filtered, timer_hit;
    logic push_req, push, pop;
    logic [9:0] event_word;

    assign is_e0     = (rx_data == 8'hE0);
    assign is_f0     = (rx_data == 8'hF0);
    assign timer_hit = (timer_reg == TW'(TIMEOUT - 1));

    always_comb begin
        is_filtered = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_filtered = 1'b1;
            default:                                  is_filtered = 1'b0;
        endcase
    end

    // Filtered bytes are only dropped with no prefix pending; after a prefix they are codes.
    assign push_req   = rx_valid && !is_e0 && !is_f0 && !((state_reg == ST_IDLE) && is_filtered);
    assign event_word = {state_reg[1], state_reg[0], rx_data};
    assign pop        = rd_en && (count_reg != '0);
    assign push       = push_req && (!full || pop);

    always_comb begin
        state_next = state_reg;
        if (rx_valid) begin
            if (is_e0) begin
                state_next = ST_EXT;
            end else if (is_f0) begin
                if (state_reg == ST_IDLE)
                    state_next = ST_BRK;
                else if (state_reg == ST_EXT)
                    state_next = ST_EXT_BRK;
            end else if (push_req) begin
                state_next = ST_IDLE;
            end
        end else if (state_reg != ST_IDLE && timer_hit) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (rx_valid || state_reg == ST_IDLE || timer_hit)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;
        end
    end

    always_ff @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
            // A dropped event outranks a simultaneous clear.
            if (push_req && full && !pop)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge Hclock) begin
        if (push)
            mem[wr_ptr_reg] <= event_word;
    end

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign irq      = !empty;
    // Storage is not reset, so the head is masked to zero while nothing is queued.
    assign rd_data  = empty ? 10'd0 : mem[rd_ptr_reg];
endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Bench for ps2_keycode_fifo: directed scenarios plus random byte traffic
// checked against a prefix-flag/queue reference model.
module tb_ps2_keycode_fifo;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 100;

    logic        Hclock = 1'b0;
    logic        Hreset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [9:0]  rd_data;
    logic        empty, full, overflow, irq;
    logic [AW:0] count;

    ps2_keycode_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Hclock(Hclock), .Hreset(Hreset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf), .irq(irq)
    );

    always #5 Hclock = ~Hclock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: pending prefix flags, time of last strobe, event queue.
    bit        m_ext, m_brk, m_ovf;
    int        m_last;
    bit [9:0]  q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_filt(input bit [7:0] b);
        return (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF);
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_last = 0;
        q.delete();
    endtask

    task automatic model_apply(input bit v, input bit [7:0] d, input bit r, input bit c);
        bit       pop, have;
        bit [9:0] ev;
        pop  = r && (q.size() > 0);
        have = 0;
        ev   = '0;
        if (v) begin
            if ((m_ext || m_brk) && (cyc - m_last > TIMEOUT)) begin
                m_ext = 0; m_brk = 0;
            end
            m_last = cyc;
            if (d == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else if (!m_ext && !m_brk && is_filt(d)) begin
                have = 0;
            end else begin
                ev = {m_brk, m_ext, d};
                have = 1;
                m_ext = 0; m_brk = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (c) m_ovf = 0;
        if (have) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("irq", 32'(irq), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk("head", 32'(rd_data), 32'(q[0]));
    endtask

    task automatic step(input bit v, input bit [7:0] d, input bit r, input bit c);
        rx_valid = v; rx_data = d; rd_en = r; clr_ovf = c;
        @(posedge Hclock);
        cyc++;
        model_apply(v, d, r, c);
        #1;
        rx_valid = 0; rd_en = 0; clr_ovf = 0;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    task automatic send(input bit [7:0] d);
        step(1, d, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
            $display("pop  entry=%03h count=%0d", rd_data, count);
            step(0, 8'h00, 1, 0);
        end
        chk("drained", 32'(empty), 32'd1);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge Hclock);
        Hreset = 0;

        // Single plain code, then pop.
        step(1, 8'h1C, 0, 0);
        chk("plain_1C", 32'(rd_data), 32'h01C);
        chk("plain_irq", 32'(irq), 32'd1);
        step(0, 8'h00, 1, 0);
        chk("pop_empty", 32'(empty), 32'd1);

        // Prefix folding with order preserved.
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_brk_head", 32'(rd_data), 32'h375);
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h6B);
        chk("three_queued", 32'(count), 32'd3);
        drain();

        // Filtered bytes in IDLE; same byte after a prefix is a code.
        send(8'hAA); send(8'hFA);
        chk("filtered_count", 32'(count), 32'd0);
        send(8'hE0); send(8'hFA);
        chk("ext_FA", 32'(rd_data), 32'h1FA);
        drain();

        // Prefix timeout and its exact boundary.
        step(1, 8'hE0, 0, 0); idle(150); step(1, 8'h1C, 0, 0);
        chk("timeout_1C", 32'(rd_data), 32'h01C);
        drain();
        step(1, 8'hE0, 0, 0); idle(TIMEOUT - 1); step(1, 8'h75, 0, 0);
        chk("gap_at_limit", 32'(rd_data), 32'h175);
        drain();
        step(1, 8'hE0, 0, 0); idle(TIMEOUT); step(1, 8'h75, 0, 0);
        chk("gap_past_limit", 32'(rd_data), 32'h075);
        drain();

        // Fill, overflow, push+pop while full, clear.
        for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        step(1, 8'h11, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1, 8'h12, 1, 0);
        chk("full_pushpop_count", 32'(count), 32'(DEPTH));
        chk("full_pushpop_head", 32'(rd_data), 32'h002);
        chk("tail_012", 32'(q[q.size()-1]), 32'h012);
        step(0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        drain();

        // Asynchronous reset between F0 and 1C with entries queued.
        send(8'h10); send(8'h11); send(8'h12);
        step(1, 8'hF0, 0, 0);
        #2;
        Hreset = 1;
        #1;
        model_reset();
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_rd_data", 32'(rd_data), 32'd0);
        @(negedge Hclock);
        Hreset = 0;
        step(1, 8'h1C, 0, 0);
        chk("post_rst_1C", 32'(rd_data), 32'h01C);
        drain();

        // Random traffic.
        for (int it = 0; it < 3000; it++) begin
            bit       v, r, c;
            bit [7:0] d;
            int       sel;
            bit [7:0] filt [6];
            filt = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
            if (it % 500 == 250) idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
            v   = ($urandom_range(0, 99) < 40);
            sel = $urandom_range(0, 9);
            if (sel == 0)      d = 8'hE0;
            else if (sel == 1) d = 8'hF0;
            else if (sel == 2) d = filt[$urandom_range(0, 5)];
            else               d = 8'($urandom);
            r = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 99) < 5);
            step(v, d, r, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
